// File: rtl/hangy_driver.sv
// Player-side initiator for the hangy core: turns new-game/guess bytes into
// next-pulse sequences on chip_input and classifies the settled chip_output.
module hangy_driver #(
    parameter int SETTLE = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_data,
    output logic [11:0] chip_input,
    input  logic [6:0]  chip_output,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [2:0]  evt_code,
    output logic [4:0]  evt_mask
);
    localparam int CNT_W = $clog2(SETTLE + 1);

    localparam logic [2:0] EV_HIT      = 3'd0;
    localparam logic [2:0] EV_MISS     = 3'd1;
    localparam logic [2:0] EV_WIN      = 3'd2;
    localparam logic [2:0] EV_LOSE     = 3'd3;
    localparam logic [2:0] EV_STARTED  = 3'd4;
    localparam logic [2:0] EV_BADCHAR  = 3'd5;
    localparam logic [2:0] EV_BADSTATE = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_EXIT_PULSE, S_EXIT_WAIT, S_PULSE, S_WAIT, S_EVENT
    } state_t;

    typedef enum logic [1:0] {PH_NOGAME, PH_PLAYING, PH_OVER} phase_t;

    state_t           state, state_nxt;
    phase_t           phase;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       index_q;
    logic [4:0]       char_q;
    logic [4:0]       snap_q;
    logic [4:0]       last_mask;
    logic             imm_q;
    logic             new_q;
    logic [2:0]       imm_code_q;
    logic             accept;
    logic             cmd_new;
    logic             cmd_letter;
    logic             cmd_imm;
    logic [2:0]       cmd_imm_code;
    logic             pulse;

    function automatic logic is_letter(input logic [7:0] b);
        return (b[7:5] == 3'b010 || b[7:5] == 3'b011) &&
               (b[4:0] >= 5'd1) && (b[4:0] <= 5'd26);
    endfunction

    // Commands that are answered without touching the core bus
    always_comb begin
        cmd_new      = cmd_data[7];
        cmd_letter   = is_letter(cmd_data);
        cmd_imm      = 1'b1;
        cmd_imm_code = EV_BADSTATE;
        if (!cmd_new && !cmd_letter)
            cmd_imm_code = EV_BADCHAR;
        else if (cmd_new)
            cmd_imm = (phase == PH_PLAYING);
        else
            cmd_imm = (phase != PH_PLAYING);
    end

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_imm)
                        state_nxt = S_WAIT;
                    else if (cmd_new && phase == PH_OVER)
                        state_nxt = S_EXIT_PULSE;
                    else
                        state_nxt = S_PULSE;
                end
            end
            S_EXIT_PULSE: state_nxt = S_EXIT_WAIT;
            S_EXIT_WAIT:  if (cnt == '0) state_nxt = S_PULSE;
            S_PULSE:      state_nxt = S_WAIT;
            S_WAIT:       if (cnt == '0) state_nxt = S_EVENT;
            S_EVENT:      if (evt_ready) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state == S_IDLE) && !evt_valid;
        pulse      = (state == S_PULSE) || (state == S_EXIT_PULSE);
        chip_input = {index_q, pulse, char_q};
    end

    // Immediate events reuse WAIT with a zero count so they land one edge after accept
    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= PH_NOGAME;
            cnt        <= '0;
            index_q    <= '0;
            char_q     <= '0;
            snap_q     <= '0;
            last_mask  <= '0;
            imm_q      <= 1'b0;
            new_q      <= 1'b0;
            imm_code_q <= '0;
            evt_valid  <= 1'b0;
            evt_code   <= '0;
            evt_mask   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        imm_q      <= cmd_imm;
                        imm_code_q <= cmd_imm_code;
                        new_q      <= cmd_new;
                        cnt        <= '0;
                        if (!cmd_imm && cmd_new)
                            index_q <= cmd_data[5:0];
                        if (!cmd_imm && !cmd_new) begin
                            char_q <= cmd_data[4:0] - 5'd1;
                            snap_q <= chip_output[4:0];
                        end
                    end
                end
                S_EXIT_PULSE: cnt <= CNT_W'(1);
                S_EXIT_WAIT:  if (cnt != '0) cnt <= cnt - 1'b1;
                S_PULSE:      cnt <= CNT_W'(SETTLE - 1);
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        evt_valid <= 1'b1;
                        if (imm_q) begin
                            evt_code <= imm_code_q;
                            evt_mask <= last_mask;
                        end else begin
                            evt_mask  <= chip_output[4:0];
                            last_mask <= chip_output[4:0];
                            if (new_q) begin
                                evt_code <= EV_STARTED;
                                phase    <= PH_PLAYING;
                            end else if (chip_output[6]) begin
                                evt_code <= EV_LOSE;
                                phase    <= PH_OVER;
                            end else if (chip_output[5]) begin
                                evt_code <= EV_WIN;
                                phase    <= PH_OVER;
                            end else if (chip_output[4:0] != snap_q) begin
                                evt_code <= EV_HIT;
                            end else begin
                                evt_code <= EV_MISS;
                            end
                        end
                    end
                end
                S_EVENT: if (evt_ready) evt_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hangy_driver.sv
// Bench for hangy_driver: a small behavioural hangy core plus a scoreboard of
// expected events (code, mask, latency in edges, next-pulse edge map).
module tb_hangy_driver;
    localparam int SETTLE = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_data = 8'h00;
    logic [11:0] chip_input;
    logic [6:0]  chip_output;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [2:0]  evt_code;
    logic [4:0]  evt_mask;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          rel_m;
    logic [31:0] pulse_map = '0;
    logic        prev_next = 1'b0;

    typedef struct {
        logic [2:0]  code;
        logic [4:0]  mask;
        int          lat;
        logic [31:0] pmap;
    } exp_t;
    exp_t sb[$];

    hangy_driver #(.SETTLE(SETTLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .chip_input (chip_input),
        .chip_output(chip_output),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_mask   (evt_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural core: result applied two edges after next; ninth wrong guess loses.
    logic [1:0] c_st;
    logic [4:0] c_g;
    logic [4:0] c_hit;
    logic       c_win, c_lose;
    int         c_miss, c_dly;
    logic [5:0] c_idx;
    logic [4:0] c_ch;

    function automatic logic [4:0] letter(input logic [5:0] idx, input int pos);
        logic [4:0] hello [5] = '{5'd7, 5'd4, 5'd11, 5'd11, 5'd14};
        logic [4:0] quick [5] = '{5'd16, 5'd20, 5'd8, 5'd2, 5'd10};
        return (idx == 6'd5) ? hello[pos] : quick[pos];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            c_st = 0; c_g = 0; c_win = 0; c_lose = 0; c_miss = 0; c_dly = 0;
            c_idx = 0; c_ch = 0;
        end else if (chip_input[5]) begin
            c_dly = 2;
            c_ch  = chip_input[4:0];
        end else if (c_dly != 0) begin
            c_dly--;
            if (c_dly == 0) begin
                case (c_st)
                    2'd0: begin
                        c_g = 0; c_miss = 0; c_idx = chip_input[11:6]; c_st = 2'd1;
                    end
                    2'd1: begin
                        c_hit = 0;
                        for (int p = 0; p < 5; p++)
                            if (letter(c_idx, p) == c_ch) c_hit[4-p] = 1'b1;
                        if (c_hit == 0) begin
                            c_miss++;
                            if (c_miss == 9) begin c_lose = 1; c_st = 2'd3; end
                        end else begin
                            c_g = c_g | c_hit;
                            if (c_g == 5'h1f) begin c_win = 1; c_st = 2'd2; end
                        end
                    end
                    default: begin c_win = 0; c_lose = 0; c_st = 2'd0; end
                endcase
            end
        end
        chip_output <= {c_lose, c_win, c_g};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // next pulse monitor: record the edge (relative to accept) at which the core sees next
    always @(negedge clk) begin
        if (!reset) check("next_double", {31'd0, prev_next & chip_input[5]}, 32'd0);
        if (chip_input[5]) begin
            rel_m = cyc + 1 - acc_cyc;
            if (rel_m >= 0 && rel_m < 31) pulse_map[rel_m] = 1'b1;
            else pulse_map[31] = 1'b1;
        end
        prev_next = chip_input[5];
    end

    task automatic send(input logic [7:0] d, input logic [2:0] code, input logic [4:0] mask,
                        input int lat, input logic [31:0] pmap);
        int n = 0;
        exp_t e;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_data  = d;
        cmd_valid = 1'b1;
        pulse_map = '0;
        acc_cyc   = cyc + 1;
        e.code = code; e.mask = mask; e.lat = lat; e.pmap = pmap;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
    endtask

    task automatic expect_event(input string tag, input int hold);
        int n = 0;
        int unstable = 0;
        exp_t e;
        logic [2:0] c0;
        logic [4:0] m0;
        while (!evt_valid && n < 200) begin @(negedge clk); n++; end
        check({tag, "_valid"}, {31'd0, evt_valid}, 32'd1);
        check({tag, "_sb"}, {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_code"}, {29'd0, evt_code}, {29'd0, e.code});
            check({tag, "_mask"}, {27'd0, evt_mask}, {27'd0, e.mask});
            check({tag, "_lat"}, cyc - acc_cyc, e.lat);
            check({tag, "_pulses"}, pulse_map, e.pmap);
        end
        c0 = evt_code;
        m0 = evt_mask;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (evt_valid !== 1'b1 || evt_code !== c0 || evt_mask !== m0 || cmd_ready !== 1'b0)
                unstable++;
        end
        check({tag, "_hold"}, unstable, 0);
        evt_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        evt_ready = 1'b0;
        check({tag, "_cleared"}, {31'd0, evt_valid}, 32'd0);
        check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] wrong [8] = '{8'h62, 8'h63, 8'h64, 8'h66, 8'h67, 8'h69, 8'h6A, 8'h6B};
        int stray;

        repeat (3) @(negedge clk);
        check("rst_chip_input", {20'd0, chip_input}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
        check("rst_evt_code", {29'd0, evt_code}, 32'd0);
        check("rst_evt_mask", {27'd0, evt_mask}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        send(8'h65, 3'd6, 5'b00000, 1, 32'h0);
        expect_event("guess_nogame", 0);
        check("nogame_chip_input", {20'd0, chip_input}, 32'd0);

        send(8'h85, 3'd4, 5'b00000, SETTLE + 1, 32'h2);
        check("new_index", {26'd0, chip_input[11:6]}, 32'd5);
        expect_event("start", 0);

        send(8'h45, 3'd0, 5'b01000, SETTLE + 1, 32'h2);
        check("guess_char", {27'd0, chip_input[4:0]}, 32'd4);
        expect_event("hit_e", 0);
        send(8'h7A, 3'd1, 5'b01000, SETTLE + 1, 32'h2);
        expect_event("miss_z", 0);

        send(8'h33, 3'd5, 5'b01000, 1, 32'h0);
        expect_event("badchar", 0);
        send(8'h81, 3'd6, 5'b01000, 1, 32'h0);
        expect_event("new_playing", 0);
        check("char_kept", {27'd0, chip_input[4:0]}, 32'd25);

        for (int i = 0; i < 8; i++) begin
            send(wrong[i], (i == 7) ? 3'd3 : 3'd1, 5'b01000, SETTLE + 1, 32'h2);
            expect_event((i == 7) ? "lose" : "miss_run", 0);
        end
        send(8'h80, 3'd4, 5'b00000, SETTLE + 4, 32'h12);
        expect_event("restart", 0);
        check("restart_index", {26'd0, chip_input[11:6]}, 32'd0);

        send(8'h61, 3'd1, 5'b00000, SETTLE + 1, 32'h2);
        expect_event("held", 20);

        send(8'h68, 3'd0, 5'b00000, 0, 32'h0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_chip_input", {20'd0, chip_input}, 32'd0);
        check("mid_rst_evt_valid", {31'd0, evt_valid}, 32'd0);
        check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        reset = 1'b0;
        sb.delete();
        stray = 0;
        repeat (SETTLE + 5) begin
            @(negedge clk);
            if (evt_valid !== 1'b0 || chip_input[5] !== 1'b0) stray++;
        end
        check("mid_rst_quiet", stray, 0);
        send(8'h41, 3'd6, 5'b00000, 1, 32'h0);
        expect_event("after_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/hangy_driver.md
Name: hangy_driver

Overview:
- Player-side initiator for the `hangy` game core.
- Accepts a byte command stream: new-game requests and ASCII letter guesses.
- Drives the core's 12-bit `chip_input` bus using its one-cycle `next` pulse protocol, then waits for the core's check chain to settle.
- Samples the 7-bit `chip_output` and returns one classified result event per command.
- Sits between a host byte source (UART/Wishbone bridge) and `hangy`, sharing its clock and reset.

Parameters:
- SETTLE, 10: cycles held after the last `next` pulse before sampling `chip_output`. Legal range ≥8; worst-case core path is 8 edges to win/lose register update.

Ports:
- clk  in  1  single clock, shared with hangy.
- reset  in  1  synchronous, active-high; must be the same reset that puts hangy in INIT_GAME.
- cmd_valid  in  1  command byte valid.
- cmd_ready  out  1  command accepted on a clk edge with cmd_valid&&cmd_ready.
- cmd_data  in  8  bit7=1: NEW game, word index = cmd_data[5:0] (bit6 ignored). bit7=0: ASCII guess.
- chip_input  out  12  to hangy: {word_index[5:0], next, char[4:0]}.
- chip_output  in  7  from hangy: {lose, win, guessed[4:0]}.
- evt_valid  out  1  result event valid.
- evt_ready  in  1  event consumed on a clk edge with evt_valid&&evt_ready.
- evt_code  out  3  0 HIT, 1 MISS, 2 WIN, 3 LOSE, 4 STARTED, 5 BADCHAR, 6 BADSTATE.
- evt_mask  out  5  `guessed` as sampled with this event.

Behaviour:
- Reset values: chip_input=0, cmd_ready=1, evt_valid=0, evt_code=0, evt_mask=0. Phase=NOGAME, FSM=IDLE.
- Reset mid-operation aborts any pulse/wait. A pending event is dropped; no partial `next` is driven.
- Phase register (mirrors core):
  - NOGAME: core in INIT_GAME.
  - PLAYING: core in GUESS.
  - OVER: core in WIN/LOSE.
- cmd_ready=1 only in IDLE with evt_valid=0; one command in flight at most.
- Letter decode:
  - 0x41–0x5A or 0x61–0x7A → code = cmd_data[4:0]−1 (0..25, 'a'=0).
  - Any other bit7=0 byte → BADCHAR.
- Immediate events (no bus activity; evt_valid registered on the edge after acceptance):
  - BADCHAR: any phase.
  - BADSTATE: guess while not PLAYING, or NEW while PLAYING.
  - evt_mask = last sampled guessed.
- FSM states: IDLE, EXIT_PULSE, EXIT_WAIT, PULSE, WAIT, EVENT.
- Guess (PLAYING):
  - Accept edge E0: char register ← code; snapshot ← chip_output[4:0]; FSM→PULSE.
  - PULSE: next=1 for exactly one cycle. Then WAIT for SETTLE cycles with next=0.
  - At the end of WAIT, sample chip_output and register the event at edge E(SETTLE+1).
  - Classification priority: lose→LOSE; win→WIN; guessed≠snapshot→HIT; else MISS.
  - WIN/LOSE set phase=OVER.
  - MISS covers both a true miss and a re-guess of an already-revealed letter (core does not distinguish).
- NEW from NOGAME:
  - index register ← cmd_data[5:0] at E0.
  - Same PULSE/WAIT sequence; event STARTED at E(SETTLE+1), evt_mask=sampled value.
  - phase=PLAYING.
- NEW from OVER:
  - EXIT_PULSE: next=1 for one cycle (core returns to INIT_GAME and clears win/lose).
  - EXIT_WAIT: 2 cycles, next=0.
  - Then PULSE/WAIT as above; STARTED at E(SETTLE+4).
- chip_input[4:0] and [11:6] hold their value until the next command that writes them. They are stable during and after every pulse (core samples index one cycle after `next`).
- `next` is never high in two consecutive cycles and never high outside PULSE/EXIT_PULSE.
- EVENT: evt_valid and fields held stable until evt_ready; then FSM→IDLE. evt_ready has no effect outside EVENT.
- cmd_valid is ignored while cmd_ready=0; cmd_data need not be held after acceptance.

Test Plan:
1. Reset, then cmd 0x65 ('e') → BADSTATE (6) one edge after accept; next never asserted; chip_input stays 0.
2. cmd 0x85 → chip_input[11:6]=5 from accept+1; next high exactly one cycle; STARTED (4), mask 00000, at edge SETTLE+1 (11).
3. Word "hello" (index 5), cmd 0x45 ('E') → chip_input[4:0]=4; HIT, mask 01000. Then cmd 0x7A ('z') → MISS, mask 01000.
4. cmd 0x33 ('3') → BADCHAR (5) next edge, no pulse. Then cmd 0x81 while PLAYING → BADSTATE.
5. Eight wrong letters → seven MISS, eighth LOSE (3). Then cmd 0x80 → next pulses at accept+1 and accept+4; STARTED at edge SETTLE+4 (14) with mask 00000.
6. Hold evt_ready=0 for 20 cycles → evt_valid/code/mask constant, cmd_ready=0. Assert reset during WAIT → chip_input=0, evt_valid=0, cmd_ready=1 the next cycle.
